// File: rtl/mem_port_pkg.sv
// ============================================================================
//  Module      : mem_port_pkg
//  Description : Shared size encodings, FSM states and store lane-merge helper
//                for the memory port controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_pkg;

    localparam logic [1:0] c_size_word = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_byte = 2'b10;
    localparam logic [1:0] c_size_rsvd = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    // Little-endian lane insert of right-aligned store data into the read word.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] merged;
        merged = old_word;
        case (size)
            c_size_half: merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
            c_size_byte: merged[{off, 3'b000} +: 8]      = wdata[7:0];
            default:     merged = wdata;
        endcase
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
//  Module      : mem_load_align
//  Description : Selects the addressed lane of a RAM word, right-aligns it and
//                sign- or zero-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_align
    import mem_port_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[{off, 3'b000} +: 8];
        w_half = word[{off[1], 4'b0000} +: 16];
        case (size)
            c_size_byte: data = {{24{sign_ext & w_byte[7]}}, w_byte};
            c_size_half: data = {{16{sign_ext & w_half[15]}}, w_half};
            default:     data = word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_ctrl.sv
// ============================================================================
//  Module      : mem_port_ctrl
//  Description : Multicycle-CPU memory port: word RAM access with sub-word
//                loads and read-modify-write sub-word stores.
//                Define MEM_PORT_ALIGN_CHECK_EN to flag misaligned/reserved
//                accesses instead of silently aligning them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int MEM_AW      = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] c_wait_last = 3'(WAIT_STATES);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic              r_sext;
    logic [2:0]        r_wait_cnt;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rdata;
    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic              w_err;
    logic              w_wait_done;
    logic [31:0]       w_ld_data;

`ifdef MEM_PORT_ALIGN_CHECK_EN
    logic r_err;

    always_comb begin
        w_size = req_size;
        w_off  = req_addr[1:0];
        case (req_size)
            c_size_word: w_err = |req_addr[1:0];
            c_size_half: w_err = req_addr[0];
            c_size_byte: w_err = 1'b0;
            default:     w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && req_valid) begin
            r_err <= w_err;
        end
    end

    assign rsp_err = (r_state == RESP) & r_err;
`else
    // Low address bits are forced to the size's natural alignment; reserved is a word.
    always_comb begin
        w_err = 1'b0;
        case (req_size)
            c_size_byte: begin
                w_size = c_size_byte;
                w_off  = req_addr[1:0];
            end
            c_size_half: begin
                w_size = c_size_half;
                w_off  = {req_addr[1], 1'b0};
            end
            default: begin
                w_size = c_size_word;
                w_off  = 2'b00;
            end
        endcase
    end

    assign rsp_err = 1'b0;
`endif

    assign w_wait_done = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = reset_n;
                if (req_valid) begin
                    if (w_err)
                        w_next = RESP;
                    else if (req_we && w_size == c_size_word)
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD:   w_next = WAIT;
            WAIT: if (w_wait_done) w_next = r_we ? WR : RESP;
            WR: begin
                mem_we = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_mem_wdata carries the raw store data until the RMW merge replaces it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we        <= 1'b0;
            r_size      <= c_size_word;
            r_off       <= 2'b00;
            r_sext      <= 1'b0;
            r_wait_cnt  <= 3'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && !w_err) begin
                        r_we        <= req_we;
                        r_size      <= w_size;
                        r_off       <= w_off;
                        r_sext      <= req_signed;
                        r_wait_cnt  <= 3'd0;
                        r_mem_addr  <= req_addr[MEM_AW+1:2];
                        r_mem_wdata <= req_wdata;
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 3'd1;
                    if (w_wait_done) begin
                        if (r_we)
                            r_mem_wdata <= lane_merge(mem_rdata, r_mem_wdata, r_size, r_off);
                        else
                            r_rdata <= w_ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_load_align u_load_align (
        .word     (mem_rdata),
        .size     (r_size),
        .off      (r_off),
        .sign_ext (r_sext),
        .data     (w_ld_data)
    );

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
// ============================================================================
//  Module      : tb_mem_port_ctrl
//  Description : Scoreboard bench for mem_port_ctrl with WAIT_STATES 0 and 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_ctrl;

    typedef struct {
        int          dut;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int          dut;
        int          cyc;
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic [29:0] mem_addr  [2];
    logic        mem_we    [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        bd_we     [2];
    logic [3:0]  bd_addr;
    logic [31:0] bd_data;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd [2];
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] ram  [16];
        logic [31:0] pipe [3];

        mem_port_ctrl #(.WAIT_STATES(2 * g), .MEM_AW(30)) u_dut (
            .clk        (clk),
            .reset_n    (rst_n[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we),
            .req_size   (req_size),
            .req_signed (req_signed),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .mem_addr   (mem_addr[g]),
            .mem_we     (mem_we[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );

        // Synchronous RAM with 1 + WAIT_STATES cycles of read latency.
        always @(posedge clk) begin
            if (bd_we[g])
                ram[bd_addr] <= bd_data;
            else if (mem_we[g])
                ram[mem_addr[g][3:0]] <= mem_wdata[g];
            pipe[0] <= ram[mem_addr[g][3:0]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rdata[g] = pipe[2 * g];
    end

    initial begin
        rsp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d] === 1'b1) begin
                    if (rsp_q.size() == 0 || rsp_q[0].dut != d) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp dut%0d cycle %0d", d, cyc);
                    end else begin
                        e = rsp_q.pop_front();
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL rsp_cycle dut%0d got %0d exp %0d", d, cyc, e.cyc);
                        end
                        checks++;
                        if (rsp_err[d] !== e.err || rsp_rdata[d] !== e.rdata) begin
                            errors++;
                            $display("FAIL rsp_data dut%0d got err=%0b rdata=%08h exp err=%0b rdata=%08h",
                                     d, rsp_err[d], rsp_rdata[d], e.err, e.rdata);
                        end
                    end
                end
                if (mem_we[d] === 1'b1) begin
                    if (wr_q.size() == 0 || wr_q[0].dut != d) begin
                        checks++; errors++;
                        $display("FAIL unexpected_mem_we dut%0d cycle %0d", d, cyc);
                    end else begin
                        w = wr_q.pop_front();
                        checks++;
                        if (cyc != w.cyc || mem_addr[d] !== w.addr || mem_wdata[d] !== w.data) begin
                            errors++;
                            $display("FAIL mem_write dut%0d got cyc=%0d addr=%0h data=%08h exp cyc=%0d addr=%0h data=%08h",
                                     d, cyc, mem_addr[d], mem_wdata[d], w.cyc, w.addr, w.data);
                        end
                    end
                end
            end
        end
    end

    task automatic backdoor(input int d, input logic [3:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        bd_we[d] = 1'b1; bd_addr = a; bd_data = v;
        @(posedge clk); #1;
        bd_we[d] = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (rsp_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL timeout pending rsp=%0d wr=%0d exp 0", rsp_q.size(), wr_q.size());
            rsp_q.delete();
            wr_q.delete();
        end
    endtask

    // wr_lat < 0: no RAM write expected. upd: response carries new load data.
    task automatic issue(input int d, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int rsp_lat, input logic exp_err, input logic upd,
                         input logic [31:0] exp_rd, input int wr_lat,
                         input logic [29:0] waddr, input logic [31:0] wword);
        int c;
        @(posedge clk); #1;
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL req_ready dut%0d got %0b exp 1", d, req_ready[d]);
        end
        c = cyc;
        req_valid[d] = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        if (upd) last_rd[d] = exp_rd;
        rsp_q.push_back('{d, c + rsp_lat, exp_err, last_rd[d]});
        if (wr_lat >= 0) wr_q.push_back('{d, c + wr_lat, waddr, wword});
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_we = ~we; req_size = ~size; req_signed = ~sgn;
        req_addr = 32'hFFFF_FFF3; req_wdata = 32'h5A5A_5A5A;
        wait_done();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; bd_we[d] = 1'b0; last_rd[d] = 32'd0;
        end
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; bd_addr = 4'd0; bd_data = 32'd0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 ||
                mem_we[d] !== 1'b0 || mem_addr[d] !== 30'd0 || mem_wdata[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got v=%0b e=%0b rd=%08h we=%0b a=%0h wd=%08h exp all 0",
                         d, rsp_valid[d], rsp_err[d], rsp_rdata[d], mem_we[d], mem_addr[d], mem_wdata[d]);
            end
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // ---- WAIT_STATES = 0 ----
        backdoor(0, 4'd1, 32'h8899_AABB);
        backdoor(0, 4'd0, 32'hCAFE_F00D);
        issue(0, 0, 2'b10, 1, 32'h5, 0, 3, 0, 1, 32'hFFFF_FFAA, -1, 0, 0);
        issue(0, 0, 2'b01, 0, 32'h6, 0, 3, 0, 1, 32'h0000_8899, -1, 0, 0);
        issue(0, 1, 2'b10, 0, 32'h4, 32'hFFFF_FF11, 4, 0, 0, 0, 3, 30'd1, 32'h8899_AA11);
        issue(0, 0, 2'b00, 0, 32'h4, 0, 3, 0, 1, 32'h8899_AA11, -1, 0, 0);
        issue(0, 0, 2'b01, 1, 32'h6, 0, 3, 0, 1, 32'hFFFF_8899, -1, 0, 0);
        issue(0, 0, 2'b10, 0, 32'h7, 0, 3, 0, 1, 32'h0000_0088, -1, 0, 0);
        issue(0, 1, 2'b01, 0, 32'h6, 32'hABCD_1234, 4, 0, 0, 0, 3, 30'd1, 32'h1234_AA11);
        issue(0, 0, 2'b10, 1, 32'h4, 0, 3, 0, 1, 32'h0000_0011, -1, 0, 0);
`ifdef MEM_PORT_ALIGN_CHECK_EN
        issue(0, 0, 2'b00, 0, 32'h2, 0, 1, 1, 0, 0, -1, 0, 0);
        issue(0, 0, 2'b11, 0, 32'h4, 0, 1, 1, 0, 0, -1, 0, 0);
        issue(0, 1, 2'b01, 0, 32'h5, 32'h0000_5555, 1, 1, 0, 0, -1, 0, 0);
`else
        issue(0, 0, 2'b00, 0, 32'h2, 0, 3, 0, 1, 32'hCAFE_F00D, -1, 0, 0);
        issue(0, 0, 2'b11, 0, 32'h4, 0, 3, 0, 1, 32'h1234_AA11, -1, 0, 0);
        issue(0, 1, 2'b01, 0, 32'h5, 32'h0000_5555, 4, 0, 0, 0, 3, 30'd1, 32'h1234_5555);
`endif

        // ---- WAIT_STATES = 2 ----
        backdoor(1, 4'd3, 32'h0102_0304);
        issue(1, 1, 2'b00, 0, 32'h8, 32'hDEAD_BEEF, 2, 0, 0, 0, 1, 30'd2, 32'hDEAD_BEEF);
        issue(1, 0, 2'b00, 0, 32'h8, 0, 5, 0, 1, 32'hDEAD_BEEF, -1, 0, 0);
        issue(1, 1, 2'b10, 0, 32'hB, 32'h0000_0077, 6, 0, 0, 0, 5, 30'd2, 32'h77AD_BEEF);
        issue(1, 0, 2'b01, 1, 32'hA, 0, 5, 0, 1, 32'h0000_77AD, -1, 0, 0);

        // Reset during WAIT of a byte store: the store must vanish.
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'hC; req_wdata = 32'h0000_0099;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        checks++;
        if (mem_we[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs got we=%0b v=%0b exp 0 0", mem_we[1], rsp_valid[1]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %0b exp 1", req_ready[1]);
        end
        last_rd[1] = 32'd0;
        repeat (8) @(posedge clk);
        issue(1, 0, 2'b00, 0, 32'hC, 0, 5, 0, 1, 32'h0102_0304, -1, 0, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 0, giving the extra RAM read-latency cycles beyond one (range 0..7).
REQ-002 The block SHALL have parameter MEM_AW, default 30, giving the RAM word-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the CPU control unit's memory request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the controller is idle and accepts a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits: 00 word, 01 half, 10 byte, 11 reserved.
REQ-009 The block SHALL have port req_signed, input, 1 bit: sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 The block SHALL have port req_addr, input, 32 bits: the byte address driven by the IorD address-select mux.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: extended load data.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the access was misaligned or reserved; it qualifies rsp_valid.
REQ-015 The block SHALL have port mem_addr, output, MEM_AW bits: the RAM word address, req_addr[MEM_AW+1:2].
REQ-016 The block SHALL have port mem_we, output, 1 bit: RAM word write strobe.
REQ-017 The block SHALL have port mem_wdata, output, 32 bits: RAM write word.
REQ-018 The block SHALL have port mem_rdata, input, 32 bits: synchronous RAM read data, valid 1+WAIT_STATES cycles after the address is presented.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WAIT, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 The controller SHALL accept a request on a rising edge in IDLE with req_valid=1 (accept cycle C), latching req_we, req_size, req_signed, req_addr and req_wdata; inputs SHALL be ignored while not in IDLE.
REQ-021 A load SHALL sequence IDLE->RD (C+1)->WAIT (WAIT_STATES+1 cycles, capturing mem_rdata in the last)->RESP, with rsp_valid in cycle C+3+WAIT_STATES.
REQ-022 A word store SHALL sequence IDLE->WR (C+1, mem_we=1, mem_wdata=latched data)->RESP (C+2).
REQ-023 A half or byte store SHALL read-modify-write: RD->WAIT->WR with the merged word->RESP, with rsp_valid in cycle C+4+WAIT_STATES.
REQ-024 Byte lanes SHALL be little-endian: byte n = bits 8n+7:8n for addr[1:0]=n; half h = bits 16h+15:16h for addr[1]=h; non-addressed lanes SHALL keep their read value.
REQ-025 Loads SHALL right-align the addressed lane and extend bits above it per req_signed.
REQ-026 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) and req_size=11 SHALL go IDLE->RESP with rsp_err=1, no RAM access, and rsp_rdata unchanged.
REQ-027 RESP SHALL last exactly one cycle and return to IDLE; a new request MAY be accepted on the next edge.
REQ-028 mem_we SHALL be 1 only in WR; mem_addr SHALL hold the latched word address from RD through WR.
REQ-029 rsp_rdata SHALL hold its value until the next successful load's RESP; stores SHALL leave it unchanged.

Reset
REQ-030 While reset_n=0 the FSM SHALL be in IDLE and all registered outputs SHALL be 0 (rsp_valid, rsp_err, rsp_rdata, mem_we, mem_addr, mem_wdata); no request SHALL be accepted.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately: no further mem_we and no rsp_valid for the aborted request.

Configuration
REQ-032 With MEM_PORT_ALIGN_CHECK_EN defined, REQ-026 SHALL apply.
REQ-033 Without MEM_PORT_ALIGN_CHECK_EN, the low address bits SHALL be forced aligned for the size (half: addr[0]=0; word: addr[1:0]=0), req_size=11 SHALL be treated as word, and rsp_err SHALL be tied 0.

Structure
REQ-034 Package mem_port_pkg SHALL hold the size encodings, the FSM state enum, and the lane-merge function.
REQ-035 Sub-module mem_load_align SHALL implement the combinational lane select and extension of REQ-025.

Verification
REQ-036 The bench SHALL cover: WAIT_STATES=0, RAM[1]=0x8899AABB, load byte signed at addr 0x5 -> rsp_valid at C+3, rsp_rdata=0xFFFFFFAA.
REQ-037 The bench SHALL cover: load half unsigned at addr 0x6, same word -> rsp_rdata=0x00008899.
REQ-038 The bench SHALL cover: store byte 0x11 at addr 0x4, same word -> one mem_we at C+3, RAM[1]=0x8899AA11, rsp_valid at C+4.
REQ-039 The bench SHALL cover: WAIT_STATES=2, word store 0xDEADBEEF at addr 0x8, then word load at addr 0x8 -> store rsp_valid at C+2, load rsp_rdata=0xDEADBEEF at C'+5.
REQ-040 The bench SHALL cover: with MEM_PORT_ALIGN_CHECK_EN, word load at addr 0x2 -> rsp_valid with rsp_err=1 at C+1, mem_we=0, rsp_rdata unchanged.
REQ-041 The bench SHALL cover: reset_n low during WAIT of a byte store -> no mem_we, no rsp_valid, req_ready=1 after release.
